// File: rtl/add_requester.sv
// Self-checking stimulus source for a registered 4-bit adder: drives operand pairs,
// compares the returned sum after one cycle of latency, and tallies pass/fail.
module add_requester #(
    parameter int unsigned NUM_TXN = 8,
    parameter logic [3:0]  A_INIT  = 4'd1,
    parameter logic [3:0]  B_INIT  = 4'd5,
    parameter logic [3:0]  A_STEP  = 4'd1,
    parameter logic [3:0]  B_STEP  = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    input  logic [4:0] sum_in,
    output logic       busy,
    output logic       done,
    output logic       mismatch,
    output logic [4:0] last_bad_sum,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_TXN - 1);

    state_t     state, state_nx;
    logic [7:0] idx, idx_nx;
    logic [4:0] expected, expected_nx;
    logic [3:0] a_nx, b_nx;
    logic       busy_nx, done_nx, mismatch_nx;
    logic [4:0] last_bad_nx;
    logic [7:0] pass_nx, fail_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            expected     <= '0;
            a_out        <= '0;
            b_out        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
            last_bad_sum <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            expected     <= expected_nx;
            a_out        <= a_nx;
            b_out        <= b_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            mismatch     <= mismatch_nx;
            last_bad_sum <= last_bad_nx;
            pass_cnt     <= pass_nx;
            fail_cnt     <= fail_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        expected_nx = expected;
        a_nx        = a_out;
        b_nx        = b_out;
        busy_nx     = busy;
        done_nx     = done;
        mismatch_nx = 1'b0;
        last_bad_nx = last_bad_sum;
        pass_nx     = pass_cnt;
        fail_nx     = fail_cnt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_nx        = A_INIT;
                    b_nx        = B_INIT;
                    expected_nx = {1'b0, A_INIT} + {1'b0, B_INIT};
                    idx_nx      = '0;
                    pass_nx     = '0;
                    fail_nx     = '0;
                    last_bad_nx = '0;
                    done_nx     = 1'b0;
                    busy_nx     = 1'b1;
                    state_nx    = WAIT;
                end
            end
            WAIT: state_nx = CHECK;
            CHECK: begin
                if (sum_in == expected) begin
                    pass_nx = pass_cnt + 8'd1;
                end else begin
                    fail_nx     = fail_cnt + 8'd1;
                    mismatch_nx = 1'b1;
                    last_bad_nx = sum_in;
                end
                if (idx == LAST_IDX) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    // Expected value is formed from the post-step operands so it
                    // lines up with what the adder captures on the next edge.
                    idx_nx      = idx + 8'd1;
                    a_nx        = a_out + A_STEP;
                    b_nx        = b_out + B_STEP;
                    expected_nx = {1'b0, a_nx} + {1'b0, b_nx};
                    state_nx    = WAIT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
